// File: rtl/axis_pkt_rr_arbiter_if.sv
// Stream bundle for the packet round-robin arbiter: NUM_INPUTS requester
// streams flattened into vectors plus the single shared output stream.
//
// Handshake: a beat moves on a stream only in a cycle where its tvalid and
// tready are both 1 at the rising clock edge; tdata and tlast are meaningful
// only while tvalid is 1, and tlast marks the final beat of a packet.
interface axis_pkt_rr_arbiter_if #(
  parameter int DWIDTH     = 32,
  parameter int NUM_INPUTS = 4
);
  logic [NUM_INPUTS*DWIDTH-1:0] i_tdata;
  logic [NUM_INPUTS-1:0]        i_tvalid;
  logic [NUM_INPUTS-1:0]        i_tlast;
  logic [NUM_INPUTS-1:0]        i_tready;
  logic [DWIDTH-1:0]            o_tdata;
  logic                         o_tvalid;
  logic                         o_tlast;
  logic                         o_tready;

  // Arbiter side: consumes the requester streams, produces the shared output.
  modport slave (
    input  i_tdata, i_tvalid, i_tlast, o_tready,
    output i_tready, o_tdata, o_tvalid, o_tlast
  );

  // Environment side: producers and the downstream consumer.
  modport master (
    output i_tdata, i_tvalid, i_tlast, o_tready,
    input  i_tready, o_tdata, o_tvalid, o_tlast
  );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-aware round-robin arbiter. One requester owns the shared output from
// grant until its tlast beat transfers, so packets never interleave. The data
// path from the owner to the output is purely combinational; one IDLE cycle
// separates consecutive packets while the next owner is chosen.
module axis_pkt_rr_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int NUM_INPUTS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  axis_pkt_rr_arbiter_if.slave          bus,
  output logic [NUM_INPUTS-1:0]         grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [0:0]                    dbg_state,
  output logic [$clog2(NUM_INPUTS)-1:0] dbg_ptr
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     own_q, own_d;   // index of the current owner
  logic [IDX_W-1:0]     ptr_q, ptr_d;   // last input that completed a packet
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic                 fire_last;
  int                   arb_best;
  int                   arb_dist;

  // Choose the valid input closest after ptr in circular order.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    arb_best = NUM_INPUTS;
    arb_dist = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      // Distance 0 means the input right after ptr, which has top priority.
      arb_dist = (i + NUM_INPUTS - 1 - int'(ptr_q)) % NUM_INPUTS;
      if (bus.i_tvalid[i] && (arb_dist < arb_best)) begin
        arb_best = arb_dist;
        pick     = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  // One-hot grant decoded from the owner index; zero whenever idle.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      grant[i] = (state_q == ST_PASS) && (own_q == IDX_W'(i));
    end
  end

  // Route the owner's stream to the output; only the owner sees o_tready.
  always_comb begin
    bus.o_tdata  = '0;
    bus.o_tvalid = 1'b0;
    bus.o_tlast  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        bus.o_tdata  = bus.i_tdata[DWIDTH*i +: DWIDTH];
        bus.o_tvalid = bus.i_tvalid[i];
        bus.o_tlast  = bus.i_tlast[i];
      end
    end
    bus.i_tready = grant & {NUM_INPUTS{bus.o_tready}};
  end

  assign fire_last = bus.o_tvalid & bus.o_tready & bus.o_tlast;

  // Next-state logic: grant in IDLE, release on the tlast transfer in PASS.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && found) begin
          state_d = ST_PASS;
          own_d   = pick;
        end
      end
      ST_PASS: begin
        // A bubble (owner tvalid low) or enable low never ends the packet.
        if (fire_last) begin
          state_d = ST_IDLE;
          ptr_d   = own_q;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any partial packet without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= IDX_W'(NUM_INPUTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_PASS);
  assign pkt_count = cnt_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
